rf_write_scheduler: RTL and testbench
=====================================

RF_WRITE_SCHEDULER -- requirements
Module: rf_write_scheduler

Interface
REQ-001 Parameters: none; data width fixed at 32 bits; register count fixed at 32 (5-bit index).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 alloc_valid  input  1  request to reserve a destination register (instruction issue).
REQ-005 alloc_rd  input  5  register index to reserve.
REQ-006 alloc_ready  output  1  combinational; reservation accepted this cycle when alloc_valid && alloc_ready.
REQ-007 rs1, rs2  input  5 each  source indices to check for pending writes.
REQ-008 rs1_busy, rs2_busy  output  1 each  combinational; the indexed register has a pending write.
REQ-009 req0_valid / req0_rd / req0_data  input  1 / 5 / 32  ALU writeback request; held stable until accepted.
REQ-010 req1_valid / req1_rd / req1_data  input  1 / 5 / 32  load writeback request; held stable until accepted.
REQ-011 req0_ready, req1_ready  output  1 each  combinational grant; a transfer occurs when valid && ready.
REQ-012 rf_we / rf_rd / rf_data  output  1 / 5 / 32  registered write port driving the register file's we / Rd / data_in.

Function
REQ-013 Scoreboard: 32-bit busy vector; bit 0 is constant 0.
REQ-014 alloc_ready = !busy[alloc_rd]; alloc_ready = 1 when alloc_rd = 0. This stalls WAW reservations.
REQ-015 Accepted alloc with alloc_rd != 0 sets busy[alloc_rd] at the next edge.
REQ-016 rs1_busy = busy[rs1]; rs2_busy = busy[rs2]. Both are purely combinational and reflect the register state.
REQ-017 The write port shall be granted to at most one requester per cycle; ready is never asserted for a requester whose valid is low.
REQ-018 Only one requester valid: that requester receives ready in the same cycle.
REQ-019 Both valid: round-robin grant; the requester not granted most recently wins.
REQ-020 A 1-bit last-grant pointer shall update only on an accepted transfer.
REQ-021 Latency: a transfer accepted in cycle N drives rf_we = 1, rf_rd = granted rd and rf_data = granted data in cycle N+1.
REQ-022 With no transfer in cycle N, rf_we = 0 in cycle N+1; rf_rd and rf_data hold their previous values.
REQ-023 A transfer with rd = 0 shall be accepted, with rf_we = 0 in the following cycle.
REQ-024 busy[rf_rd] clears at the end of any cycle in which rf_we = 1, i.e. at the same edge the register file captures the data.
REQ-025 Simultaneous clear and accepted alloc to the same index: set wins and busy stays 1.
REQ-026 A write to an index that is not busy is permitted; rf_we issues normally and busy is unchanged.
REQ-027 Throughput: one register-file write per cycle sustained. No combinational path shall exist from req*_data to rf_*.

Reset
REQ-028 On rst high, asynchronously: busy = 0, rf_we = 0, rf_rd = 0, rf_data = 0, and the last-grant pointer selects req1 so that req0 wins the first tie.
REQ-029 While rst is high, req0_ready and req1_ready shall be 0 and no transfer is accepted. A reset mid-transfer discards the pending rf_we.
REQ-030 After rst deasserts, alloc_ready = 1 for every index and rs1_busy = rs2_busy = 0.

Verification
REQ-031 Reserve/clear: alloc x5 -> rs1 = 5 gives rs1_busy = 1 next cycle. req0 writes x5 = 0xDEADBEEF -> next cycle rf_we = 1, rf_rd = 5, rf_data = 0xDEADBEEF; following cycle rs1_busy = 0.
REQ-032 Tie arbitration after reset: both requesters valid (x3 = 0x11, x4 = 0x22) for 2 cycles -> rf_rd sequence 3 then 4. Ready grant order is req0 then req1; no cycle has both ready.
REQ-033 Sustained alternation: both valid for 6 cycles -> grants alternate 0,1,0,1,0,1, and rf_we = 1 on 6 consecutive cycles.
REQ-034 WAW stall and set-wins: alloc x7 while busy[7] = 1 -> alloc_ready = 0. When rf_we clears x7 in the same cycle as a new alloc of x7 is accepted, busy[7] = 1 afterward.
REQ-035 x0 handling: alloc x0 -> alloc_ready = 1 and rs1_busy(0) = 0. req1 writes x0 = 0xFFFFFFFF -> req1_ready = 1, next cycle rf_we = 0.
REQ-036 Async reset: assert rst between clock edges with busy = 0x0000_00F0 and a transfer in flight -> busy = 0 and rf_we = 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/rf_write_scheduler.sv
// Register-file write scheduler: destination scoreboard plus a two-requester
// round-robin arbiter feeding a single registered register-file write port.
module rf_write_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc_valid,
  input  logic [4:0]  alloc_rd,
  output logic        alloc_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  input  logic        req0_valid,
  input  logic [4:0]  req0_rd,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_rd,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  logic [31:0] busy, busy_nxt;
  logic        last_gnt;   // 1: req1 was granted most recently
  logic        gnt0, gnt1, xfer, alloc_fire;
  wb_req_t     win;

  // Scoreboard lookups; x0 is never busy so it never stalls.
  assign alloc_ready = (alloc_rd == 5'd0) || !busy[alloc_rd];
  assign alloc_fire  = alloc_valid && alloc_ready && (alloc_rd != 5'd0);
  assign rs1_busy    = busy[rs1];
  assign rs2_busy    = busy[rs2];

  // Round-robin grant; a lone requester wins outright, ties go to the one not last served.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || last_gnt)) gnt0 = 1'b1;
      else if (req1_valid)                         gnt1 = 1'b1;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = gnt0 | gnt1;
  assign win        = gnt1 ? wb_req_t'{req1_rd, req1_data} : wb_req_t'{req0_rd, req0_data};

  // Next scoreboard: clear on the write-port edge, then set so a same-index alloc wins.
  always_comb begin
    busy_nxt = busy;
    if (rf_we)      busy_nxt[rf_rd]    = 1'b0;
    if (alloc_fire) busy_nxt[alloc_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard and arbitration pointer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      last_gnt <= 1'b1;
    end else begin
      busy <= busy_nxt;
      if (xfer) last_gnt <= gnt1;
    end
  end

  // Registered write port; writes to x0 are accepted but never reach the file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_rd   <= '0;
      rf_data <= '0;
    end else begin
      rf_we <= xfer && (win.rd != 5'd0);
      if (xfer) begin
        rf_rd   <= win.rd;
        rf_data <= win.data;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler; each task drives one scenario and checks inline.
module tb_rf_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_rd, req1_rd;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  int nvec = 0;
  int nerr = 0;

  rf_write_scheduler dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    #2 rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alloc_valid = 0; alloc_rd = 0; rs1 = 0; rs2 = 0;
    req0_valid = 1; req0_rd = 5'd9; req0_data = 32'h1234;
    req1_valid = 1; req1_rd = 5'd8; req1_data = 32'h5678;
    tick(); tick();
    nvec++; if (req0_ready !== 1'b0) begin nerr++; $display("FAIL rst_req0_ready got %b exp 0", req0_ready); end
    nvec++; if (req1_ready !== 1'b0) begin nerr++; $display("FAIL rst_req1_ready got %b exp 0", req1_ready); end
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL rst_rf_we got %b exp 0", rf_we); end
    nvec++; if (rf_rd !== 5'd0 || rf_data !== 32'd0) begin nerr++; $display("FAIL rst_rf_port got %0d/%h exp 0/0", rf_rd, rf_data); end
    req0_valid = 0; req1_valid = 0;
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 32; i += 7) begin
      alloc_rd = 5'(i); rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      nvec++; if (alloc_ready !== 1'b1 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
        nerr++; $display("FAIL post_rst_idx%0d got ready=%b b1=%b b2=%b exp 1/0/0", i, alloc_ready, rs1_busy, rs2_busy);
      end
    end
  endtask

  task automatic test_reserve_clear();
    alloc_valid = 1; alloc_rd = 5'd5; rs1 = 5'd5;
    #1;
    nvec++; if (alloc_ready !== 1'b1) begin nerr++; $display("FAIL rc_alloc_ready got %b exp 1", alloc_ready); end
    tick();
    alloc_valid = 0;
    #1;
    nvec++; if (rs1_busy !== 1'b1) begin nerr++; $display("FAIL rc_busy_set got %b exp 1", rs1_busy); end
    req0_valid = 1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    nvec++; if (req0_ready !== 1'b1) begin nerr++; $display("FAIL rc_req0_ready got %b exp 1", req0_ready); end
    tick();
    req0_valid = 0;
    #1;
    nvec++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
      nerr++; $display("FAIL rc_write got we=%b rd=%0d data=%h exp 1/5/deadbeef", rf_we, rf_rd, rf_data);
    end
    nvec++; if (rs1_busy !== 1'b1) begin nerr++; $display("FAIL rc_busy_hold got %b exp 1", rs1_busy); end
    tick();
    nvec++; if (rs1_busy !== 1'b0) begin nerr++; $display("FAIL rc_busy_clear got %b exp 0", rs1_busy); end
    nvec++; if (rf_we !== 1'b0 || rf_rd !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
      nerr++; $display("FAIL rc_idle_hold got we=%b rd=%0d data=%h exp 0/5/deadbeef", rf_we, rf_rd, rf_data);
    end
  endtask

  task automatic test_tie();
    do_reset();
    req0_valid = 1; req0_rd = 5'd3; req0_data = 32'h11;
    req1_valid = 1; req1_rd = 5'd4; req1_data = 32'h22;
    #1;
    nvec++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      nerr++; $display("FAIL tie_c0_ready got %b%b exp 10", req0_ready, req1_ready);
    end
    tick();
    req0_data = 32'h13;  // req0 accepted; it presents a fresh request while req1 waits
    #1;
    nvec++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_data !== 32'h11) begin
      nerr++; $display("FAIL tie_c0_write got we=%b rd=%0d data=%h exp 1/3/11", rf_we, rf_rd, rf_data);
    end
    nvec++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      nerr++; $display("FAIL tie_c1_ready got %b%b exp 01", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 0; req1_valid = 0;
    #1;
    nvec++; if (rf_we !== 1'b1 || rf_rd !== 5'd4 || rf_data !== 32'h22) begin
      nerr++; $display("FAIL tie_c1_write got we=%b rd=%0d data=%h exp 1/4/22", rf_we, rf_rd, rf_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic        g;
    logic [31:0] exp_data;
    req0_valid = 1; req0_rd = 5'd10; req0_data = 32'h100;
    req1_valid = 1; req1_rd = 5'd11; req1_data = 32'h201;
    rs1 = 5'd10; rs2 = 5'd11;
    for (int i = 0; i < 6; i++) begin
      g = i[0];
      exp_data = (g ? 32'h200 : 32'h100) + 32'(i);
      #1;
      nvec++; if (req0_ready !== !g || req1_ready !== g) begin
        nerr++; $display("FAIL b2b_ready%0d got %b%b exp %b%b", i, req0_ready, req1_ready, !g, g);
      end
      tick();
      if (g) req1_data = 32'h200 + 32'(i + 2);
      else   req0_data = 32'h100 + 32'(i + 2);
      nvec++; if (rf_we !== 1'b1 || rf_rd !== (g ? 5'd11 : 5'd10) || rf_data !== exp_data) begin
        nerr++; $display("FAIL b2b_write%0d got we=%b rd=%0d data=%h exp 1/%0d/%h", i, rf_we, rf_rd, rf_data, g ? 11 : 10, exp_data);
      end
    end
    req0_valid = 0; req1_valid = 0;
    tick();
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL b2b_idle got %b exp 0", rf_we); end
    nvec++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      nerr++; $display("FAIL b2b_nonbusy got %b%b exp 00", rs1_busy, rs2_busy);
    end
  endtask

  task automatic test_waw();
    rs1 = 5'd7;
    alloc_valid = 1; alloc_rd = 5'd7;
    tick();
    #1;
    nvec++; if (rs1_busy !== 1'b1) begin nerr++; $display("FAIL waw_busy got %b exp 1", rs1_busy); end
    nvec++; if (alloc_ready !== 1'b0) begin nerr++; $display("FAIL waw_stall got %b exp 0", alloc_ready); end
    tick();
    nvec++; if (alloc_ready !== 1'b0) begin nerr++; $display("FAIL waw_stall2 got %b exp 0", alloc_ready); end
    alloc_valid = 0;
    req0_valid = 1; req0_rd = 5'd7; req0_data = 32'h77;
    tick();
    req0_valid = 0;
    nvec++; if (rf_we !== 1'b1 || rf_rd !== 5'd7) begin nerr++; $display("FAIL waw_write got we=%b rd=%0d exp 1/7", rf_we, rf_rd); end
    tick();
    nvec++; if (rs1_busy !== 1'b0 || alloc_ready !== 1'b1) begin
      nerr++; $display("FAIL waw_cleared got busy=%b ready=%b exp 0/1", rs1_busy, alloc_ready);
    end
    // Write to non-busy x7 lands in the same cycle a new alloc of x7 is accepted.
    req0_valid = 1; req0_data = 32'h78;
    tick();
    req0_valid = 0;
    alloc_valid = 1; alloc_rd = 5'd7;
    #1;
    nvec++; if (rf_we !== 1'b1 || alloc_ready !== 1'b1) begin
      nerr++; $display("FAIL waw_setwin_pre got we=%b ready=%b exp 1/1", rf_we, alloc_ready);
    end
    tick();
    alloc_valid = 0;
    #1;
    nvec++; if (rs1_busy !== 1'b1) begin nerr++; $display("FAIL waw_set_wins got %b exp 1", rs1_busy); end
    req0_valid = 1;
    tick();
    req0_valid = 0;
    tick();
    nvec++; if (rs1_busy !== 1'b0) begin nerr++; $display("FAIL waw_final_clear got %b exp 0", rs1_busy); end
  endtask

  task automatic test_x0();
    alloc_valid = 1; alloc_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    nvec++; if (alloc_ready !== 1'b1) begin nerr++; $display("FAIL x0_alloc_ready got %b exp 1", alloc_ready); end
    tick();
    alloc_valid = 0;
    #1;
    nvec++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      nerr++; $display("FAIL x0_busy got %b%b exp 00", rs1_busy, rs2_busy);
    end
    req1_valid = 1; req1_rd = 5'd0; req1_data = 32'hFFFFFFFF;
    #1;
    nvec++; if (req1_ready !== 1'b1) begin nerr++; $display("FAIL x0_req1_ready got %b exp 1", req1_ready); end
    tick();
    req1_valid = 0;
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL x0_rf_we got %b exp 0", rf_we); end
  endtask

  task automatic test_async_reset();
    for (int i = 4; i < 8; i++) begin
      alloc_valid = 1; alloc_rd = 5'(i);
      tick();
    end
    alloc_valid = 0;
    rs1 = 5'd4; rs2 = 5'd7;
    #1;
    nvec++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
      nerr++; $display("FAIL ar_busy_pre got %b%b exp 11", rs1_busy, rs2_busy);
    end
    req0_valid = 1; req0_rd = 5'd4; req0_data = 32'hCAFE0004;
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_rd = 5'd6; req1_data = 32'hCAFE0006;
    nvec++; if (rf_we !== 1'b1) begin nerr++; $display("FAIL ar_inflight got %b exp 1", rf_we); end
    #2 rst = 1'b1;
    #1;
    nvec++; if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_data !== 32'd0) begin
      nerr++; $display("FAIL ar_port got we=%b rd=%0d data=%h exp 0/0/0", rf_we, rf_rd, rf_data);
    end
    nvec++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      nerr++; $display("FAIL ar_busy got %b%b exp 00", rs1_busy, rs2_busy);
    end
    nvec++; if (req1_ready !== 1'b0) begin nerr++; $display("FAIL ar_req1_ready got %b exp 0", req1_ready); end
    tick();
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL ar_no_xfer got %b exp 0", rf_we); end
    req1_valid = 0;
    #2 rst = 1'b0;
    #1;
    alloc_rd = 5'd6;
    #1;
    nvec++; if (alloc_ready !== 1'b1) begin nerr++; $display("FAIL ar_alloc_ready got %b exp 1", alloc_ready); end
  endtask

  initial begin
    test_reset();
    test_reserve_clear();
    test_tie();
    test_back_to_back();
    test_waw();
    test_x0();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
